// File: rtl/redundancy_mode_sequencer.sv
// Redundancy mode sequencer: gates issue traffic, tracks in-flight transactions
// and performs drain -> resync -> commit whenever the requested mode changes.
module redundancy_mode_sequencer #(
  parameter int MaxOutstanding = 4,
  parameter int ResyncCycles   = 3,
  localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  output logic            busy_o,
  output logic            mode_o,
  output logic            resync_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            resp_valid_i,
  input  logic            resp_ready_i,
  output logic            resp_valid_o,
  output logic            resp_ready_o,
  output logic [CntW-1:0] outstanding_o
);

  localparam int RcntW = (ResyncCycles > 1) ? $clog2(ResyncCycles) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    RESYNC = 2'd2
  } stateT;

  stateT             r_state;
  stateT             w_stateNext;
  logic              r_mode;
  logic              w_modeNext;
  logic              r_target;
  logic              w_targetNext;
  logic [RcntW-1:0]  r_rcnt;
  logic [RcntW-1:0]  w_rcntNext;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cntNext;
  logic              w_full;
  logic              w_blk;
  logic              w_issue;
  logic              w_retire;
  logic              w_resync;

  // Busy reacts combinationally so the controller sees the switch the same cycle it asks.
  assign busy_o        = (r_state != IDLE) | (enable_i != r_mode);
  assign w_full        = (r_cnt == CntW'(MaxOutstanding));
  assign w_blk         = busy_o | w_full;
  assign out_valid_o   = in_valid_i & ~w_blk;
  assign in_ready_o    = out_ready_i & ~w_blk;
  assign resp_valid_o  = resp_valid_i;
  assign resp_ready_o  = resp_ready_i;
  assign w_issue       = out_valid_o & out_ready_i;
  assign w_retire      = resp_valid_i & resp_ready_i;
  assign mode_o        = r_mode;
  assign resync_o      = w_resync;
  assign outstanding_o = r_cnt;

  always_comb begin
    w_cntNext = r_cnt;
    if (w_issue && !w_retire && !w_full) begin
      w_cntNext = r_cnt + CntW'(1);
    end else if (w_retire && !w_issue && (r_cnt != '0)) begin
      w_cntNext = r_cnt - CntW'(1);
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_modeNext   = r_mode;
    w_targetNext = r_target;
    w_rcntNext   = r_rcnt;
    w_resync     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_i != r_mode) w_stateNext = DRAIN;
      end
      DRAIN: begin
        // A withdrawn request abandons the switch without touching the mode.
        if (enable_i == r_mode) begin
          w_stateNext = IDLE;
        end else if (r_cnt == '0) begin
          w_stateNext  = RESYNC;
          w_targetNext = enable_i;
          w_rcntNext   = RcntW'(ResyncCycles - 1);
        end
      end
      RESYNC: begin
        w_resync = 1'b1;
        if (r_rcnt != '0) begin
          w_rcntNext = r_rcnt - RcntW'(1);
        end else begin
          w_modeNext  = r_target;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_mode   <= 1'b0;
      r_target <= 1'b0;
      r_rcnt   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_mode   <= w_modeNext;
      r_target <= w_targetNext;
      r_rcnt   <= w_rcntNext;
      r_cnt    <= w_cntNext;
    end
  end

  // A completion with nothing in flight is an upstream protocol violation.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_retire && (r_cnt == '0)));

endmodule

// File: tb/tb_redundancy_mode_sequencer.sv
// Scoreboard bench for redundancy_mode_sequencer: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_redundancy_mode_sequencer;

  logic       clk;
  logic       rstN;
  logic       enable;
  logic       busy;
  logic       mode;
  logic       resync;
  logic       inValid;
  logic       inReady;
  logic       outValid;
  logic       outReady;
  logic       respValidIn;
  logic       respReadyIn;
  logic       respValidOut;
  logic       respReadyOut;
  logic [2:0] outstanding;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       busy;
    logic       mode;
    logic       resync;
    logic       inReady;
    logic       outValid;
    logic       respValid;
    logic       respReady;
    logic [2:0] cnt;
    string      name;
  } expT;

  expT expQ[$];

  redundancy_mode_sequencer #(
    .MaxOutstanding(4),
    .ResyncCycles(3)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .enable_i(enable),
    .busy_o(busy),
    .mode_o(mode),
    .resync_o(resync),
    .in_valid_i(inValid),
    .in_ready_o(inReady),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .resp_valid_i(respValidIn),
    .resp_ready_i(respReadyIn),
    .resp_valid_o(respValidOut),
    .resp_ready_o(respReadyOut),
    .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs just after the edge and queues what the outputs must show.
  task automatic applyStimulus(
    input string name,
    input logic r, input logic en, input logic iv, input logic ordy,
    input logic rv, input logic rr,
    input logic eBusy, input logic eMode, input logic eResync,
    input logic eInReady, input logic eOutValid, input logic [2:0] eCnt
  );
    expT e;
    @(posedge clk);
    #1;
    rstN        = r;
    enable      = en;
    inValid     = iv;
    outReady    = ordy;
    respValidIn = rv;
    respReadyIn = rr;
    e.busy      = eBusy;
    e.mode      = eMode;
    e.resync    = eResync;
    e.inReady   = eInReady;
    e.outValid  = eOutValid;
    e.respValid = rv;
    e.respReady = rr;
    e.cnt       = eCnt;
    e.name      = name;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      checkOutput({e.name, ".busy"},      {7'd0, busy},         {7'd0, e.busy});
      checkOutput({e.name, ".mode"},      {7'd0, mode},         {7'd0, e.mode});
      checkOutput({e.name, ".resync"},    {7'd0, resync},       {7'd0, e.resync});
      checkOutput({e.name, ".inReady"},   {7'd0, inReady},      {7'd0, e.inReady});
      checkOutput({e.name, ".outValid"},  {7'd0, outValid},     {7'd0, e.outValid});
      checkOutput({e.name, ".respValid"}, {7'd0, respValidOut}, {7'd0, e.respValid});
      checkOutput({e.name, ".respReady"}, {7'd0, respReadyOut}, {7'd0, e.respReady});
      checkOutput({e.name, ".cnt"},       {5'd0, outstanding},  {5'd0, e.cnt});
    end
  end

  initial begin
    rstN        = 1'b0;
    enable      = 1'b0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    respValidIn = 1'b0;
    respReadyIn = 1'b0;

    //                name     rst en iv or rv rr  busy mode rs inR outV cnt
    applyStimulus("rst",      0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'd0);
    applyStimulus("t1c0",     1, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 3'd0);
    applyStimulus("t1c1",     1, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 3'd1);
    applyStimulus("t1c2",     1, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 3'd2);
    applyStimulus("t1c3",     1, 0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 3'd3);
    applyStimulus("t1full",   1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3'd4);
    applyStimulus("t1hold",   1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 3'd4);
    applyStimulus("t4ret4",   1, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 3'd4);
    applyStimulus("t4ret3",   1, 0, 0, 1, 1, 1,  0, 0, 0, 1, 0, 3'd3);
    applyStimulus("t4both2a", 1, 0, 1, 1, 1, 1,  0, 0, 0, 1, 1, 3'd2);
    applyStimulus("t4both2b", 1, 0, 1, 1, 1, 1,  0, 0, 0, 1, 1, 3'd2);
    applyStimulus("t4ret2",   1, 0, 0, 1, 1, 1,  0, 0, 0, 1, 0, 3'd2);
    applyStimulus("t4ret1",   1, 0, 0, 1, 1, 1,  0, 0, 0, 1, 0, 3'd1);
    applyStimulus("t4empty",  1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'd0);
    applyStimulus("t2tog",    1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t2drain",  1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t2rs0",    1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t2rs1",    1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t2rs2",    1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t2done",   1, 1, 1, 1, 0, 0,  0, 1, 0, 1, 1, 3'd0);
    applyStimulus("t3fill1",  1, 1, 1, 1, 0, 0,  0, 1, 0, 1, 1, 3'd1);
    applyStimulus("t3fill2",  1, 1, 1, 1, 0, 0,  0, 1, 0, 1, 1, 3'd2);
    applyStimulus("t3tog",    1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 3'd3);
    applyStimulus("t3wait",   1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 3'd3);
    applyStimulus("t3ret3",   1, 0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 3'd3);
    applyStimulus("t3ret2",   1, 0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 3'd2);
    applyStimulus("t3ret1",   1, 0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 3'd1);
    applyStimulus("t3zero",   1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 3'd0);
    applyStimulus("t3rs0",    1, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 3'd0);
    applyStimulus("t3rs1",    1, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 3'd0);
    applyStimulus("t3rs2",    1, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 3'd0);
    applyStimulus("t3done",   1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 3'd0);
    applyStimulus("t5tog",    1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t5back",   1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t5idle0",  1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 3'd0);
    applyStimulus("t5idle1",  1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 3'd0);
    applyStimulus("t6tog",    1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6drain",  1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6rs0",    1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t6rst",    0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6rstLo",  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6redo",   1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6drain2", 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6rs2a",   1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t6rs2b",   1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t6rs2c",   1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3'd0);
    applyStimulus("t6mode1",  1, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0, 3'd0);
    applyStimulus("t6rstM1",  0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 3'd0);
    applyStimulus("t6after",  1, 0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 3'd0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drainQueue: got %0d pending expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
